// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types and helpers for the RAM-port arbiter:
//   - state_e  : arbiter FSM states (IDLE / READ / WRITE)
//   - owner_e  : which requester owns the current transaction (IF / LS)
//   - SIZE_*   : load/store size codes (bytes-1)
//   - byte_of  : extract byte k of a 32-bit little-endian word
//   - put_byte : replace byte k of a 32-bit little-endian word
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd3;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (k)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the fetch port, the load/store port and the byte-wide RAM port.
//   modport slave  : the arbiter's view (takes requests + RAM read byte, drives done/data + RAM bus)
//   modport master : the environment's view (requesters, RAM, UART status)
//   Signals:
//     if_req/if_addr -> if_done/if_data            instruction fetch (one 32-bit word)
//     ls_req/ls_wr/ls_size/ls_addr/ls_wdata -> ls_done/ls_rdata   1/2/4-byte load/store
//     mem_din (RAM read byte), mem_dout/mem_a/mem_wr (RAM write byte, address, write strobe)
//     io_buffer_full                               UART output buffer full
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;

    logic        ls_req;
    logic        ls_wr;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport slave (
        input  if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata, mem_din, io_buffer_full,
        output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

    modport master (
        output if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata, mem_din, io_buffer_full,
        input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Sole owner of the 8-bit RAM port. Grants either the instruction-fetch path
//   (4-byte refill) or the load/store buffer (1/2/4-byte access), serialises the
//   access into byte beats and returns a one-cycle done pulse with assembled data.
// Ports:
//   clk_in    system clock
//   rst_in    synchronous active-high reset
//   rdy_in    low = pause, every register holds
//   rollback  pipeline flush: aborts reads, suppresses grant in IDLE; writes complete
//   bus       mem_arbiter_if.slave (fetch port, load/store port, RAM port, io_buffer_full)
// Build option:
//   IO_STALL_EN  when defined, writes at or above IO_ADDR_BASE are neither granted
//                nor advanced while io_buffer_full is high. When undefined,
//                io_buffer_full is ignored and IO addresses behave as RAM.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [31:0] IO_ADDR_BASE = 32'h0003_0000
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          rollback,
    mem_arbiter_if.slave  bus
);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [2:0]  beat_q, beat_d;     // beats addressed/issued so far
    logic [2:0]  last_q, last_d;     // index of final byte (N-1)
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic        starve_q, starve_d; // IF lost the previous contested grant
    logic [31:0] mem_a_q, mem_a_d;
    logic        mem_wr_q, mem_wr_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        if_done_q, if_done_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic        io_grant_block;
    logic        io_beat_block;
    logic        ls_ok;
    logic        pick_if;

`ifdef IO_STALL_EN
    assign io_grant_block = bus.ls_wr && (bus.ls_addr >= IO_ADDR_BASE) && bus.io_buffer_full;
    assign io_beat_block  = ((base_q + 32'(beat_q)) >= IO_ADDR_BASE) && bus.io_buffer_full;
`else
    // io_buffer_full and IO_ADDR_BASE have no effect in this build.
    logic unused_io;
    assign unused_io      = bus.io_buffer_full ^ (|IO_ADDR_BASE);
    assign io_grant_block = 1'b0;
    assign io_beat_block  = 1'b0;
`endif

    // LS normally wins; IF wins a contested grant right after losing one.
    assign ls_ok   = bus.ls_req && !io_grant_block;
    assign pick_if = bus.if_req && (!ls_ok || starve_q);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_d     = beat_q;
        last_d     = last_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        mem_a_d    = mem_a_q;
        mem_wr_d   = 1'b0;
        mem_dout_d = mem_dout_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (!rollback && (ls_ok || bus.if_req)) begin
                    starve_d = !pick_if && bus.if_req;
                    beat_d   = 3'd1;
                    if (pick_if) begin
                        owner_d = OWN_IF;
                        base_d  = bus.if_addr;
                        mem_a_d = bus.if_addr;
                        last_d  = 3'd3;
                        state_d = ST_READ;
                    end else begin
                        owner_d    = OWN_LS;
                        base_d     = bus.ls_addr;
                        mem_a_d    = bus.ls_addr;
                        last_d     = {1'b0, bus.ls_size};
                        wdata_d    = bus.ls_wdata;
                        ls_rdata_d = '0;   // unused upper bytes read back as zero
                        if (bus.ls_wr) begin
                            state_d    = ST_WRITE;
                            mem_wr_d   = 1'b1;
                            mem_dout_d = bus.ls_wdata[7:0];
                        end else begin
                            state_d = ST_READ;
                        end
                    end
                end
            end

            ST_READ: begin
                if (rollback) begin
                    state_d = ST_IDLE;
                end else begin
                    // mem_din belongs to the address driven on the previous edge.
                    if (owner_q == OWN_IF)
                        if_data_d = put_byte(if_data_q, 2'(beat_q - 3'd1), bus.mem_din);
                    else
                        ls_rdata_d = put_byte(ls_rdata_q, 2'(beat_q - 3'd1), bus.mem_din);
                    if (beat_q == last_q + 3'd1) begin
                        state_d   = ST_IDLE;
                        if_done_d = (owner_q == OWN_IF);
                        ls_done_d = (owner_q == OWN_LS);
                    end else begin
                        mem_a_d = base_q + 32'(beat_q);
                        beat_d  = beat_q + 3'd1;
                    end
                end
            end

            ST_WRITE: begin
                // Writes are committed: rollback does not interrupt them.
                if (beat_q == last_q + 3'd1) begin
                    state_d   = ST_IDLE;
                    ls_done_d = 1'b1;
                end else if (!io_beat_block) begin
                    mem_wr_d   = 1'b1;
                    mem_a_d    = base_q + 32'(beat_q);
                    mem_dout_d = byte_of(wdata_q, beat_q[1:0]);
                    beat_d     = beat_q + 3'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            starve_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_wr_q   <= 1'b0;
            mem_dout_q <= '0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            starve_q   <= starve_d;
            mem_a_q    <= mem_a_d;
            mem_wr_q   <= mem_wr_d;
            mem_dout_q <= mem_dout_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // Transaction descriptor: only meaningful after a grant, so no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            owner_q <= owner_d;
            last_q  <= last_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.mem_a    = mem_a_q;
    assign bus.mem_wr   = mem_wr_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.if_done  = if_done_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_done  = ls_done_q;
    assign bus.ls_rdata = ls_rdata_q;

endmodule
